// File: rtl/spi_xfer_scheduler.sv
// Round-robin scheduler that runs complete SPI transactions on an APB SPI master:
// register programming, CTRL polling with timeout, optional RDATA fetch, one response per request.
module spi_xfer_scheduler #(
  parameter int          N_REQ    = 2,
  parameter logic [15:0] CLK_DIV  = 16'h0004,
  parameter logic [15:0] POLL_MAX = 16'd1023
) (
  input  logic                pclk_i,
  input  logic                rst_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  logic [8*N_REQ-1:0]  req_cmd_i,
  input  logic [16*N_REQ-1:0] req_addr_i,
  input  logic [8*N_REQ-1:0]  req_len_i,
  input  logic [32*N_REQ-1:0] req_wdata_i,
  input  logic [N_REQ-1:0]    req_rx_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [1:0]          rsp_id_o,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_timeout_o,
  output logic                busy_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [3:0]          paddr_o,
  output logic [31:0]         pwdata_o,
  input  logic [31:0]         prdata_i,
  input  logic                pready_i
);

  typedef enum logic [2:0] {IDLE, GRANT, WRITE, POLL, READ, RESP} state_t;
  typedef enum logic [1:0] {SETUP, ACCESS, GAP} phase_t;

  state_t      state, state_nxt;
  phase_t      phase, phase_nxt;
  logic [2:0]  widx;
  logic [15:0] poll_cnt;
  logic [15:0] poll_inc;
  logic        fin;
  logic        tmo;
  logic [31:0] rdata;
  logic [1:0]  gid;
  logic [1:0]  rr_ptr;
  logic [7:0]  cmd;
  logic [15:0] addr;
  logic [7:0]  len;
  logic [31:0] wdata;
  logic        rx;

  logic        gnt_found;
  logic [1:0]  gnt_idx;
  logic [3:0]  vld4;
  logic [3:0]  rdy4;
  logic        xfer;
  logic        acc_done;
  logic        take;
  logic        rsp_fire;
  logic        ctrl_idle;

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    vld4      = 4'(req_valid_i);
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!gnt_found && vld4[j[1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = j[1:0];
      end
    end
  end

  assign xfer      = (state == WRITE) || (state == POLL) || (state == READ);
  assign acc_done  = xfer && (phase == ACCESS) && pready_i;
  assign take      = (state == GRANT) && gnt_found;
  assign rsp_fire  = (state == RESP) && rsp_ready_i;
  assign ctrl_idle = (prdata_i[1:0] == 2'b00);
  assign poll_inc  = (poll_cnt >= POLL_MAX) ? POLL_MAX : poll_cnt + 16'd1;

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      phase <= SETUP;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      IDLE:  if (|req_valid_i) state_nxt = GRANT;
      GRANT: begin
        if (gnt_found) begin
          state_nxt = WRITE;
          phase_nxt = SETUP;
        end else begin
          state_nxt = IDLE;
        end
      end
      WRITE, POLL, READ: begin
        case (phase)
          SETUP:  phase_nxt = ACCESS;
          ACCESS: if (pready_i) phase_nxt = GAP;
          default: begin
            phase_nxt = SETUP;
            if (state == WRITE && widx == 3'd5)
              state_nxt = POLL;
            else if (state == POLL && fin)
              state_nxt = (!tmo && rx) ? READ : RESP;
            else if (state == READ)
              state_nxt = RESP;
          end
        endcase
      end
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      widx     <= 3'd0;
      poll_cnt <= 16'd0;
      fin      <= 1'b0;
      tmo      <= 1'b0;
      rdata    <= 32'd0;
      gid      <= 2'd0;
      rr_ptr   <= 2'd0;
      cmd      <= 8'd0;
      addr     <= 16'd0;
      len      <= 8'd0;
      wdata    <= 32'd0;
      rx       <= 1'b0;
    end else begin
      if (take) begin
        cmd      <= req_cmd_i[int'(gnt_idx)*8 +: 8];
        addr     <= req_addr_i[int'(gnt_idx)*16 +: 16];
        len      <= req_len_i[int'(gnt_idx)*8 +: 8];
        wdata    <= req_wdata_i[int'(gnt_idx)*32 +: 32];
        rx       <= req_rx_i[gnt_idx];
        gid      <= gnt_idx;
        rr_ptr   <= (gnt_idx == 2'(N_REQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
        widx     <= 3'd0;
        poll_cnt <= 16'd0;
        fin      <= 1'b0;
        tmo      <= 1'b0;
        rdata    <= 32'd0;
      end
      if (acc_done && state == WRITE) widx <= widx + 3'd1;
      // A finished CTRL read wins over reaching the poll limit on the same read.
      if (acc_done && state == POLL) begin
        poll_cnt <= poll_inc;
        if (ctrl_idle) begin
          fin <= 1'b1;
        end else if (poll_inc == POLL_MAX) begin
          fin <= 1'b1;
          tmo <= 1'b1;
        end
      end
      if (acc_done && state == READ) rdata <= prdata_i;
      if (rsp_fire) begin
        poll_cnt <= 16'd0;
        fin      <= 1'b0;
        tmo      <= 1'b0;
        rdata    <= 32'd0;
      end
    end
  end

  always_comb begin
    rdy4        = 4'b0001 << gnt_idx;
    req_ready_o = take ? rdy4[N_REQ-1:0] : '0;
    psel_o      = xfer && (phase != GAP);
    penable_o   = xfer && (phase == ACCESS);
    pwrite_o    = psel_o && (state == WRITE);
    paddr_o     = 4'd0;
    pwdata_o    = 32'd0;
    if (psel_o) begin
      case (state)
        WRITE:   paddr_o = (widx == 3'd4) ? 4'd5 : {1'b0, widx};
        POLL:    paddr_o = 4'd5;
        default: paddr_o = 4'd4;
      endcase
    end
    if (pwrite_o) begin
      case (widx)
        3'd0:    pwdata_o = {24'd0, cmd};
        3'd1:    pwdata_o = {16'd0, addr};
        3'd2:    pwdata_o = {24'd0, len};
        3'd3:    pwdata_o = wdata;
        default: pwdata_o = {CLK_DIV, 14'd0, rx, 1'b1};
      endcase
    end
  end

  assign busy_o        = (state != IDLE);
  assign rsp_valid_o   = (state == RESP);
  assign rsp_id_o      = gid;
  assign rsp_rdata_o   = rdata;
  assign rsp_timeout_o = tmo;

endmodule
